value_to_ascii_4: RTL and testbench

- Upstream feeder for the 4-character ASCII string renderer.
- Takes an unsigned binary parameter value (band frequency, gain or Q readout) and converts it to four ASCII decimal digits with an iterative double-dabble engine.
- Presents the result on a 32-bit string bus with a one-cycle load strobe, so the renderer latches a complete, stable string.

---
 rtl/value_to_ascii_4.sv | 146 ++++++++++++++
 tb/tb_value_to_ascii_4.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/value_to_ascii_4.sv
// Converts an unsigned value to four ASCII decimal digits using an iterative double-dabble engine.
// Optional macro LEADING_ZERO_BLANK_EN replaces leading zero digits with spaces (units digit kept).
module value_to_ascii_4 #(
    parameter int IN_WIDTH = 14
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [IN_WIDTH-1:0] value_in,
    input  logic                start,
    output logic                busy,
    output logic                overflow,
    output logic [31:0]         string_out,
    output logic                load_string
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);
    localparam logic [IN_WIDTH-1:0] MAX_VAL = IN_WIDTH'(9999);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [31:0] RESET_STR = 32'h20202030;
`else
    localparam logic [31:0] RESET_STR = 32'h30303030;
`endif

    typedef enum logic [1:0] {IDLE, CONVERT, FORMAT, DONE} state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [15:0]         bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [31:0]         fmt_q, fmt_d;
    logic [31:0]         string_q, string_d;
    logic                overflow_q, overflow_d;
    logic                load_q, load_d;

    function automatic logic [31:0] to_ascii(input logic [15:0] bcd);
        logic [31:0] r;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        r = 32'h0;
        for (int i = 3; i >= 0; i--) begin
            logic [7:0] ch;
            ch = 8'h30 + {4'h0, bcd[i*4 +: 4]};
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && (i != 0) && (bcd[i*4 +: 4] == 4'd0)) begin
                ch = 8'h20;
            end else begin
                lead = 1'b0;
            end
`endif
            r[i*8 +: 8] = ch;
        end
        return r;
    endfunction

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        fmt_d      = fmt_q;
        string_d   = string_q;
        overflow_d = overflow_q;
        load_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(value_in) > 32'd9999) begin
                        shift_d = MAX_VAL;
                        ovf_d   = 1'b1;
                    end else begin
                        shift_d = value_in;
                        ovf_d   = 1'b0;
                    end
                    bcd_d   = 16'h0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                fmt_d   = to_ascii(bcd_q);
                state_d = DONE;
            end
            DONE: begin
                // Outputs update together so the renderer never sees a partial string
                string_d   = fmt_q;
                overflow_d = ovf_q;
                load_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= 16'h0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            fmt_q      <= RESET_STR;
            string_q   <= RESET_STR;
            overflow_q <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            fmt_q      <= fmt_d;
            string_q   <= string_d;
            overflow_q <= overflow_d;
            load_q     <= load_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign overflow    = overflow_q;
    assign string_out  = string_q;
    assign load_string = load_q;

endmodule

// File: tb/tb_value_to_ascii_4.sv
// Randomized self-checking bench for value_to_ascii_4 (14-bit and 10-bit instances).
module tb_value_to_ascii_4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [31:0] RESET_STR = 32'h20202030;
`else
    localparam logic [31:0] RESET_STR = 32'h30303030;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [13:0] value14 = '0;
    logic        start14 = 1'b0;
    logic        busy14, ovf14, load14;
    logic [31:0] str14;
    logic [9:0]  value10 = '0;
    logic        start10 = 1'b0;
    logic        busy10, ovf10, load10;
    logic [31:0] str10;

    int errors = 0;
    int checks = 0;

    value_to_ascii_4 #(.IN_WIDTH(14)) dut14 (
        .Clk(Clk), .Reset(Reset), .value_in(value14), .start(start14),
        .busy(busy14), .overflow(ovf14), .string_out(str14), .load_string(load14)
    );

    value_to_ascii_4 #(.IN_WIDTH(10)) dut10 (
        .Clk(Clk), .Reset(Reset), .value_in(value10), .start(start10),
        .busy(busy10), .overflow(ovf10), .string_out(str10), .load_string(load10)
    );

    always #5 Clk = ~Clk;

    // Reference: clamp, split into decimal digits arithmetically, map to ASCII
    function automatic logic [31:0] model_string(input int v);
        int c;
        int d[4];
        logic [31:0] r;
        logic [7:0] ch;
`ifdef LEADING_ZERO_BLANK_EN
        bit lead;
        lead = 1'b1;
`endif
        c = (v > 9999) ? 9999 : v;
        d[0] = c / 1000;
        d[1] = (c / 100) % 10;
        d[2] = (c / 10) % 10;
        d[3] = c % 10;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ch = 8'(48 + d[i]);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && i < 3 && d[i] == 0) ch = 8'h20;
            else lead = 1'b0;
`endif
            r = {r[23:0], ch};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Launches one conversion on the 14-bit DUT and observes it until load_string
    task automatic run14(input int v, output int lat, output int busy_cnt,
                         output logic [31:0] s, output logic ov);
        value14 = 14'(v);
        start14 = 1'b1;
        tick();
        start14 = 1'b0;
        lat = -1;
        busy_cnt = 0;
        s = 32'h0;
        ov = 1'b0;
        for (int n = 0; n <= 40 && lat < 0; n++) begin
            if (n > 0) tick();
            if (load14) begin
                lat = n;
                s = str14;
                ov = ovf14;
            end else if (busy14) begin
                busy_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #3;
        checks++;
        if (busy14 !== 1'b0 || ovf14 !== 1'b0 || load14 !== 1'b0 || str14 !== RESET_STR) begin
            errors++;
            $display("[TB] FAIL reset: busy=%b ovf=%b load=%b str=%h, required 0 0 0 %h",
                     busy14, ovf14, load14, str14, RESET_STR);
        end
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [31:0] s;
        logic ov;
        run14(1234, lat, bc, s, ov);
        checks++;
        if (lat !== 16 || bc !== 16) begin
            errors++;
            $display("[TB] FAIL basic_latency: lat=%0d busy=%0d, required 16 16", lat, bc);
        end
        checks++;
        if (s !== model_string(1234) || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_value: str=%h ovf=%b, required %h 0", s, ov, model_string(1234));
        end
        tick();
        checks++;
        if (load14 !== 1'b0 || str14 !== model_string(1234)) begin
            errors++;
            $display("[TB] FAIL basic_pulse: load=%b str=%h, required 0 %h", load14, str14, model_string(1234));
        end
    endtask

    task automatic test_small_values();
        int vals[3] = '{0, 70, 5};
        int lat, bc;
        logic [31:0] s;
        logic ov;
        foreach (vals[i]) begin
            run14(vals[i], lat, bc, s, ov);
            tick();
            checks++;
            if (lat !== 16 || s !== model_string(vals[i]) || ov !== 1'b0) begin
                errors++;
                $display("[TB] FAIL small_%0d: lat=%0d str=%h ovf=%b, required 16 %h 0",
                         vals[i], lat, s, ov, model_string(vals[i]));
            end
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        logic [31:0] s;
        logic ov;
        run14(12000, lat, bc, s, ov);
        tick();
        checks++;
        if (s !== 32'h39393939 || ov !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_clamp: str=%h ovf=%b, required 39393939 1", s, ov);
        end
        tick();
        checks++;
        if (ovf14 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_hold: ovf=%b, required 1", ovf14);
        end
        run14(5, lat, bc, s, ov);
        tick();
        checks++;
        if (s !== model_string(5) || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_clear: str=%h ovf=%b, required %h 0", s, ov, model_string(5));
        end
    endtask

    task automatic test_random();
        int v, lat, bc;
        logic [31:0] s;
        logic ov;
        for (int k = 0; k < 24; k++) begin
            v = int'($urandom_range(0, 16383));
            run14(v, lat, bc, s, ov);
            tick();
            checks++;
            if (lat !== 16 || s !== model_string(v) || ov !== (v > 9999)) begin
                errors++;
                $display("[TB] FAIL random_%0d: lat=%0d str=%h ovf=%b, required 16 %h %b",
                         v, lat, s, ov, model_string(v), (v > 9999));
            end
        end
    endtask

    task automatic test_ignore_start();
        int loads = 0;
        logic [31:0] s = 32'h0;
        value14 = 14'd4321;
        start14 = 1'b1;
        tick();
        start14 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (load14) begin
                loads++;
                s = str14;
            end
            if (n == 5) begin
                value14 = 14'd999;
                start14 = 1'b1;
            end else if (n == 6) begin
                start14 = 1'b0;
            end
        end
        checks++;
        if (loads !== 1 || s !== model_string(4321)) begin
            errors++;
            $display("[TB] FAIL ignore_start: loads=%0d str=%h, required 1 %h", loads, s, model_string(4321));
        end
    endtask

    task automatic test_back_to_back();
        int lat1 = -1;
        int lat2 = -1;
        logic [31:0] s1 = 32'h0;
        logic [31:0] s2 = 32'h0;
        value14 = 14'd4321;
        start14 = 1'b1;
        tick();
        value14 = 14'd999;
        for (int n = 1; n <= 40 && lat1 < 0; n++) begin
            tick();
            if (load14) begin
                lat1 = n;
                s1 = str14;
            end
        end
        checks++;
        if (lat1 !== 16 || s1 !== model_string(4321)) begin
            errors++;
            $display("[TB] FAIL b2b_first: lat=%0d str=%h, required 16 %h", lat1, s1, model_string(4321));
        end
        for (int m = 1; m <= 40 && lat2 < 0; m++) begin
            tick();
            if (m == 1) start14 = 1'b0;
            if (load14) begin
                lat2 = m;
                s2 = str14;
            end
        end
        start14 = 1'b0;
        checks++;
        if (lat2 !== 17 || s2 !== 32'h30393939 || ovf14 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second: gap=%0d str=%h ovf=%b, required 17 30393939 0", lat2, s2, ovf14);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int loads = 0;
        value14 = 14'd9876;
        start14 = 1'b1;
        tick();
        start14 = 1'b0;
        for (int n = 1; n <= 8; n++) tick();
        Reset = 1'b1;
        #1;
        checks++;
        if (busy14 !== 1'b0 || ovf14 !== 1'b0 || load14 !== 1'b0 || str14 !== RESET_STR) begin
            errors++;
            $display("[TB] FAIL reset_mid: busy=%b ovf=%b load=%b str=%h, required 0 0 0 %h",
                     busy14, ovf14, load14, str14, RESET_STR);
        end
        tick();
        Reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (load14) loads++;
        end
        checks++;
        if (loads !== 0 || str14 !== RESET_STR) begin
            errors++;
            $display("[TB] FAIL reset_mid_abort: loads=%0d str=%h, required 0 %h", loads, str14, RESET_STR);
        end
    endtask

    task automatic test_width10();
        int v, lat;
        logic [31:0] s;
        logic ov;
        for (int k = 0; k < 6; k++) begin
            v = (k == 0) ? 1023 : int'($urandom_range(0, 1023));
            value10 = 10'(v);
            start10 = 1'b1;
            tick();
            start10 = 1'b0;
            lat = -1;
            s = 32'h0;
            ov = 1'b1;
            for (int n = 1; n <= 40 && lat < 0; n++) begin
                tick();
                if (load10) begin
                    lat = n;
                    s = str10;
                    ov = ovf10;
                end
            end
            tick();
            checks++;
            if (lat !== 12 || s !== model_string(v) || ov !== 1'b0) begin
                errors++;
                $display("[TB] FAIL width10_%0d: lat=%0d str=%h ovf=%b, required 12 %h 0",
                         v, lat, s, ov, model_string(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_values();
        test_overflow();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_width10();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
